// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle for conv_window_gen.
// The master drives pixels and observes windows; the slave is the window generator.
interface conv_window_gen_if #(
  parameter int CH = 8,
  parameter int DW = 16,
  parameter int K  = 3
);
  logic                   in_valid;
  logic [CH*DW-1:0]       in_pixel;
  logic                   win_valid;
  logic [CH*K*K*DW-1:0]   win_act;
  logic                   frame_done;

  modport master (
    output in_valid, in_pixel,
    input  win_valid, win_act, frame_done
  );

  modport slave (
    input  in_valid, in_pixel,
    output win_valid, win_act, frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// Raster pixel stream -> 3x3 sliding windows (valid padding), 1-cycle latency, no backpressure.
// Define CONV_WINDOW_STRIDE2_EN to emit only windows whose top-left corner is at (even, even).
module conv_window_gen #(
  parameter int CH    = 8,
  parameter int DW    = 16,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int K     = 3
) (
  input  logic               clk,
  input  logic               rstn,
  conv_window_gen_if.slave   bus
);

  localparam int PW = CH*DW;
  localparam int AW = CH*K*K*DW;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

`ifdef CONV_WINDOW_STRIDE2_EN
  localparam bit STRIDE2 = 1'b1;
  localparam int LAST_R  = ((IMG_H-3)/2)*2 + 2;
  localparam int LAST_C  = ((IMG_W-3)/2)*2 + 2;
`else
  localparam bit STRIDE2 = 1'b0;
  localparam int LAST_R  = IMG_H-1;
  localparam int LAST_C  = IMG_W-1;
`endif

  typedef logic [PW-1:0] pix_t;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  pix_t          lb0_q [IMG_W];
  pix_t          lb0_d [IMG_W];
  pix_t          lb1_q [IMG_W];
  pix_t          lb1_d [IMG_W];
  pix_t          sr_q  [K][K];
  pix_t          sr_d  [K][K];
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;
  logic [AW-1:0] win_act_q, win_act_d;
  logic          emit;

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    lb0_d        = lb0_q;
    lb1_d        = lb1_q;
    sr_d         = sr_q;
    emit         = 1'b0;
    win_act_d    = win_act_q;

    if (bus.in_valid) begin
      // Line buffers are read from the _q copies, so the old row values shift out before being overwritten.
      lb1_d[col_q] = lb0_q[col_q];
      lb0_d[col_q] = bus.in_pixel;

      for (int ky = 0; ky < K; ky++) begin
        for (int kx = 0; kx < K-1; kx++) begin
          sr_d[ky][kx] = sr_q[ky][kx+1];
        end
      end
      sr_d[0][K-1] = lb1_q[col_q];
      sr_d[1][K-1] = lb0_q[col_q];
      sr_d[2][K-1] = bus.in_pixel;

      if (col_q == CW'(IMG_W-1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H-1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      // Columns 0..1 hold previous-row pixels in the shift registers; they never emit.
      emit = (row_q >= RW'(2)) && (col_q >= CW'(2)) &&
             (!STRIDE2 || (!row_q[0] && !col_q[0]));
    end

    win_valid_d  = emit;
    frame_done_d = emit && (row_q == RW'(LAST_R)) && (col_q == CW'(LAST_C));

    if (emit) begin
      for (int ch = 0; ch < CH; ch++) begin
        for (int t = 0; t < K*K; t++) begin
          win_act_d[ch*K*K*DW + t*DW +: DW] = sr_d[t/K][t%K][ch*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_act_q    <= '0;
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
      for (int ky = 0; ky < K; ky++) begin
        for (int kx = 0; kx < K; kx++) begin
          sr_q[ky][kx] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_act_q    <= win_act_d;
      lb0_q        <= lb0_d;
      lb1_q        <= lb1_d;
      sr_q         <= sr_d;
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.win_act    = win_act_q;

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Producer for the depthwise-conv layer input interface: converts a raster-order pixel stream (CH channels × DW bits per pixel) into K×K sliding windows, each emitted as one flat CH×K×K×DW vector with a valid strobe.
- Sits between the previous layer's output stream and a 3×3 depthwise layer.
- Holds K-1 line buffers and a K-deep column shift register per window row.
- Valid-padding convolution; stride 1 by default.

Parameters:
- CH, 8, channels per pixel
- DW, 16, bits per channel sample (signed, passed through untouched)
- IMG_W, 16, image width in pixels (≥K)
- IMG_H, 16, image height in pixels (≥K)
- K, 3, window size; only 3 is supported

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- in_valid  input  1  pixel present this cycle; no backpressure, always accepted
- in_pixel  input  CH*DW  channel c at bits [c*DW +: DW]
- win_valid  output  1  window present on win_act this cycle
- win_act  output  CH*K*K*DW  window; channel c at [c*K*K*DW +: K*K*DW], tap t within channel at [t*DW +: DW]
- frame_done  output  1  one-cycle pulse coincident with the frame's last window

Behaviour:
- Reset: win_valid=0, win_act=0, frame_done=0. Column/row counters=0. Line buffers and shift registers cleared to 0.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance only on in_valid.
  - col wraps to 0 and increments row.
  - After (IMG_H-1, IMG_W-1), both wrap to 0; the next pixel starts a new frame.
- Line buffers:
  - LB0 holds row r-1 and LB1 holds row r-2, each IMG_W entries indexed by col.
  - On an accepted pixel: LB1[col]←LB0[col], LB0[col]←in_pixel.
  - Read-before-write in the same cycle.
- Shift registers: three rows (r-2, r-1, r), each 3 pixels deep, shifted on every accepted pixel with LB1[col], LB0[col] and in_pixel.
- Emission:
  - Accepting pixel (r,c) with r≥2 and c≥2 makes win_valid=1 on the next cycle.
  - The window covers rows r-2..r and cols c-2..c.
  - Latency is 1 cycle from pixel acceptance to window.
- Tap order: t = ky*3+kx; ky=0 is row r-2, kx=0 is col c-2, so t=8 is the newest pixel (r,c).
- Output hold: win_act holds its value when win_valid=0. win_valid is 0 in any cycle after in_valid=0.
- Window count per frame: (IMG_H-2)×(IMG_W-2), i.e. 196 at defaults.
- Row crossing: at c=0 and c=1 the shift registers contain previous-row pixels; no window is emitted, so these are harmless.
- frame_done: asserted together with win_valid for the window whose newest pixel is (IMG_H-1, IMG_W-1).
- Bubbles: in_valid gaps of any length do not change the window sequence or its contents.
- Reset mid-frame: outputs return to 0 asynchronously. The next accepted pixel is treated as (0,0), and no stale-row window is ever emitted.

Optional Feature:
- Macro: CONV_WINDOW_STRIDE2_EN.
- Defined: emission additionally requires r and c even, giving windows at top-left positions (even, even).
  - Count per frame: ((IMG_H-3)/2+1)×((IMG_W-3)/2+1), i.e. 49 at defaults.
  - frame_done accompanies the last emitted window, newest pixel (14,14) at defaults.
  - Line buffers and shifting are unchanged.
- Undefined: stride 1 as above.

Test Plan:
- Stimulus encoding for all scenarios: channel ch of pixel (r,c) = r*256 + c*16 + ch.
- Defaults, contiguous 16×16 frame:
  - 196 win_valid pulses; the first one appears the cycle after (2,2) is accepted.
  - First window: ch0 tap0=0x000, tap4=0x110, tap8=0x220; ch7 tap8 = win_act[1151:1136] = 0x227.
  - Last window: ch0 tap8=0xFF0, with frame_done=1 in that cycle only.
- Same frame with random in_valid gaps (30% idle) -> identical 196-window sequence and contents; win_valid never asserted during idle-following cycles.
- Two back-to-back frames:
  - Second frame yields 196 windows.
  - No window while frame-2 rows 0-1 stream.
  - First frame-2 window ch0 tap0=0x000, tap8=0x220.
- rstn pulsed after row 5 col 7:
  - win_valid/frame_done/win_act read 0 immediately.
  - A fresh full frame then yields exactly 196 correct windows.
- CONV_WINDOW_STRIDE2_EN defined, contiguous frame:
  - 49 windows.
  - First window ch0 tap8=0x220, second ch0 tap8=0x240.
  - Last window ch0 tap8=0xEE0 with frame_done=1.
